pipe_ctrl: RTL and testbench

Parametrised elastic pipeline controller: a chain of `DEPTH` payload registers with per-stage valid bits and valid/ready handshakes. Upstream and downstream stall each other via backpressure, bubbles collapse, and a selective flush kills the younger stages. It replaces the fixed, always-set pipeline registers between core stages, so the IF/ID…EX/WB chain can stall and squash without per-register glue.

---
 rtl/core101_pkg.sv | 19 +
 rtl/pipe_skid.sv | 50 +++++
 rtl/pipe_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core101_pkg.sv
// Shared defaults and helpers for the core pipeline blocks.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package core101_pkg;

  localparam int CORE_DEPTH      = 4;
  localparam int CORE_DATA_WIDTH = 32;

  // Number of set bits in a vector of up to 64 bits (callers zero-extend).
  function automatic int popcount(input logic [63:0] vec);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n = n + int'(vec[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_skid.sv
// One-entry skid register behind the exit stage of pipe_ctrl.
// Latency: 0 cycles when the sink is ready, 1 cycle when the exit item parks here.
// Backpressure: a full skid entry holds the exit stage; it drains when sink_ready is high.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   flush_all           - squash that reaches the exit stage; also empties the skid
//   exit_valid/data     - item currently held in the last pipeline stage
//   sink_ready          - downstream accepts this cycle
//   skid_valid/data     - registered skid entry
//   skid_nxt            - skid_valid value after the next edge (for occupancy)
module pipe_skid #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_all,
  input  logic                  exit_valid,
  input  logic [DATA_WIDTH-1:0] exit_data,
  input  logic                  sink_ready,
  output logic                  skid_valid,
  output logic [DATA_WIDTH-1:0] skid_data,
  output logic                  skid_nxt
);

  // Park the exit item only when nobody takes it directly and the entry is free.
  logic capture;
  assign capture = exit_valid & !skid_valid & !sink_ready & !flush_all;

  always_comb begin
    skid_nxt = skid_valid;
    if (flush_all) begin
      skid_nxt = 1'b0;
    end else if (skid_valid) begin
      if (sink_ready) skid_nxt = 1'b0;
    end else if (capture) begin
      skid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      skid_valid <= skid_nxt;
      if (capture) skid_data <= exit_data;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Elastic pipeline controller: DEPTH payload stages with valid/ready, bubble collapse, selective flush.
// Latency: DEPTH cycles from input transfer to out_valid_out; 1 item/cycle with out_ready_in held high.
// Backpressure: ready chain propagates out_ready_in to in_ready_out (registered break with PIPE_CTRL_SKID_EN).
// Ports:
//   clock_in, reset_in              - clock, synchronous active-high reset
//   in_valid_in/in_ready_out/in_data_in    - upstream handshake and payload
//   out_valid_out/out_ready_in/out_data_out - downstream handshake and payload
//   flush_in, flush_stage_in        - squash stages 0..flush_stage_in (saturates to DEPTH-1)
//   stage_valid_out, occupancy_out  - debug valid bits and registered entry count
// Optional feature macro: PIPE_CTRL_SKID_EN adds a one-entry skid register after the exit stage.
module pipe_ctrl
  import core101_pkg::*;
#(
  parameter int DATA_WIDTH = CORE_DATA_WIDTH,
  parameter int DEPTH      = CORE_DEPTH,
  parameter int IDX_W      = $clog2(DEPTH),
  parameter int CNT_W      = $clog2(DEPTH + 2)
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  in_valid_in,
  output logic                  in_ready_out,
  input  logic [DATA_WIDTH-1:0] in_data_in,
  output logic                  out_valid_out,
  input  logic                  out_ready_in,
  output logic [DATA_WIDTH-1:0] out_data_out,
  input  logic                  flush_in,
  input  logic [IDX_W-1:0]      flush_stage_in,
  output logic [DEPTH-1:0]      stage_valid_out,
  output logic [CNT_W-1:0]      occupancy_out
);

  logic [DEPTH-1:0]      valid;
  logic [DEPTH-1:0]      nxt_valid;
  logic [DATA_WIDTH-1:0] data [DEPTH];
  logic [DEPTH:0]        rdy;
  logic                  exit_ready;
  logic                  skid_nxt;
  logic                  in_xfer;
  logic [IDX_W-1:0]      k_sat;

  always_comb begin
    k_sat = flush_stage_in;
    if (int'(flush_stage_in) > DEPTH - 1) k_sat = IDX_W'(DEPTH - 1);
  end

  // A stage may load when it is empty or everything ahead of it moves.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = exit_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = !valid[i] | rdy[i + 1];
    end
  end

  assign in_ready_out = rdy[0] & !flush_in & !reset_in;
  assign in_xfer      = in_valid_in & in_ready_out;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic                  kill;
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  nv;
    logic                  v;
    logic [DATA_WIDTH-1:0] d;

    assign kill = flush_in && (int'(k_sat) >= i);

    if (i == 0) begin : g_head
      assign src_valid = in_xfer;
      assign src_data  = in_data_in;
    end else begin : g_body
      // A squashed younger item must not leak forward: the stage above loads a bubble.
      assign src_valid = valid[i - 1] && !(flush_in && (int'(k_sat) >= i - 1));
      assign src_data  = data[i - 1];
    end

    always_comb begin
      nv = v;
      if (kill)        nv = 1'b0;
      else if (rdy[i]) nv = src_valid;
    end

    // Payload only moves with a valid item; bubbles leave stale data behind.
    always_ff @(posedge clock_in) begin
      if (reset_in) begin
        v <= 1'b0;
        d <= '0;
      end else begin
        v <= nv;
        if (!kill && rdy[i] && src_valid) d <= src_data;
      end
    end

    assign valid[i]     = v;
    assign data[i]      = d;
    assign nxt_valid[i] = nv;
  end

`ifdef PIPE_CTRL_SKID_EN
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  flush_all;

  assign flush_all = flush_in && (int'(k_sat) == DEPTH - 1);

  pipe_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk        (clock_in),
    .rst        (reset_in),
    .flush_all  (flush_all),
    .exit_valid (valid[DEPTH-1]),
    .exit_data  (data[DEPTH-1]),
    .sink_ready (out_ready_in),
    .skid_valid (skid_valid),
    .skid_data  (skid_data),
    .skid_nxt   (skid_nxt)
  );

  // Registered exit ready cuts the out_ready_in -> in_ready_out path.
  assign exit_ready    = !skid_valid;
  assign out_valid_out = (skid_valid | valid[DEPTH-1]) & !reset_in;
  assign out_data_out  = skid_valid ? skid_data : data[DEPTH-1];
`else
  assign exit_ready    = out_ready_in;
  assign skid_nxt      = 1'b0;
  assign out_valid_out = valid[DEPTH-1] & !reset_in;
  assign out_data_out  = data[DEPTH-1];
`endif

  assign stage_valid_out = valid;

  // Counting the next-state valid bits keeps transfers, squashes and an exit
  // delivered during a full flush consistent without special cases.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      occupancy_out <= '0;
    end else begin
      occupancy_out <= CNT_W'(popcount(64'(nxt_valid)) + int'(skid_nxt));
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (DEPTH=4, DATA_WIDTH=32, default build).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        flush;
  logic [1:0]  flush_stage;
  logic [3:0]  stage_valid;
  logic [2:0]  occupancy;

  int vectors;
  int errors;

  pipe_ctrl #(
    .DATA_WIDTH (32),
    .DEPTH      (4)
  ) dut (
    .clock_in        (clk),
    .reset_in        (rst),
    .in_valid_in     (in_valid),
    .in_ready_out    (in_ready),
    .in_data_in      (in_data),
    .out_valid_out   (out_valid),
    .out_ready_in    (out_ready),
    .out_data_out    (out_data),
    .flush_in        (flush),
    .flush_stage_in  (flush_stage),
    .stage_valid_out (stage_valid),
    .occupancy_out   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush = 1'b0; flush_stage = '0;
    tick(); tick();
    #1;
    vectors++;
    if (stage_valid !== 4'b0000 || occupancy !== 3'd0) begin
      errors++; $display("FAIL reset_state: stage_valid=%b occ=%0d want 0000/0", stage_valid, occupancy);
    end
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: out_valid=%b out_data=%h in_ready=%b want 0/0/0", out_valid, out_data, in_ready);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
    tick();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8);
      in_data  = 32'(c + 1);
      #1;
      if (c < 8) begin
        vectors++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL stream_in_ready c=%0d: got %b want 1", c, in_ready);
        end
      end
      vectors++;
      if (c < 4) begin
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL stream_latency c=%0d: out_valid=%b want 0", c, out_valid);
        end
      end else if (out_valid !== 1'b1 || out_data !== 32'(c - 3)) begin
        errors++; $display("FAIL stream_out c=%0d: valid=%b data=%h want 1/%h", c, out_valid, out_data, 32'(c - 3));
      end
      if (c >= 4 && c <= 8) begin
        vectors++;
        if (occupancy !== 3'd4) begin
          errors++; $display("FAIL stream_occ c=%0d: got %0d want 4", c, occupancy);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      errors++; $display("FAIL stream_drained: valid=%b occ=%0d want 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_data = 32'h11 + 32'(c);
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL bp_fill_ready c=%0d: got %b want 1", c, in_ready);
      end
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = 32'h99;
      #1;
      vectors++;
      if (in_ready !== 1'b0 || occupancy !== 3'd4 || stage_valid !== 4'b1111) begin
        errors++; $display("FAIL bp_stall c=%0d: in_ready=%b occ=%0d sv=%b want 0/4/1111", c, in_ready, occupancy, stage_valid);
      end
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'h11) begin
        errors++; $display("FAIL bp_hold c=%0d: valid=%b data=%h want 1/11", c, out_valid, out_data);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'h11 + 32'(j)) begin
        errors++; $display("FAIL bp_drain j=%0d: valid=%b data=%h want 1/%h", j, out_valid, out_data, 32'h11 + 32'(j));
      end
      tick();
    end
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      errors++; $display("FAIL bp_empty: valid=%b occ=%0d want 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c == 0 || c == 3);
      in_data  = (c == 0) ? 32'hA : 32'hB;
      #1;
      if (c == 4) begin
        vectors++;
        if (stage_valid !== 4'b1001) begin
          errors++; $display("FAIL bubble_gap: got %b want 1001", stage_valid);
        end
      end
      tick();
    end
    #1;
    vectors++;
    if (stage_valid !== 4'b1100 || occupancy !== 3'd2 || out_data !== 32'hA) begin
      errors++; $display("FAIL bubble_collapse: sv=%b occ=%0d data=%h want 1100/2/a", stage_valid, occupancy, out_data);
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'hB) begin
      errors++; $display("FAIL bubble_second: valid=%b data=%h want 1/b", out_valid, out_data);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      errors++; $display("FAIL bubble_empty: valid=%b occ=%0d want 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_data = 32'(c + 1);
      tick();
    end
    flush = 1'b1; flush_stage = 2'd1; in_valid = 1'b1; in_data = 32'h55;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_refuse: in_ready=%b want 0", in_ready);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    vectors++;
    if (stage_valid !== 4'b1100 || occupancy !== 3'd2) begin
      errors++; $display("FAIL flush_state: sv=%b occ=%0d want 1100/2", stage_valid, occupancy);
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h1) begin
      errors++; $display("FAIL flush_exit1: valid=%b data=%h want 1/1", out_valid, out_data);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h2) begin
      errors++; $display("FAIL flush_exit2: valid=%b data=%h want 1/2", out_valid, out_data);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      errors++; $display("FAIL flush_empty: valid=%b occ=%0d want 0/0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush_output();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_data = 32'h21 + 32'(c);
      tick();
    end
    in_valid = 1'b0; flush = 1'b1; flush_stage = 2'd3; out_ready = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h21 || in_ready !== 1'b0) begin
      errors++; $display("FAIL flushout_deliver: valid=%b data=%h in_ready=%b want 1/21/0", out_valid, out_data, in_ready);
    end
    tick();
    flush = 1'b0;
    #1;
    vectors++;
    if (stage_valid !== 4'b0000 || occupancy !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flushout_clear: sv=%b occ=%0d valid=%b want 0000/0/0", stage_valid, occupancy, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = 32'h31 + 32'(c);
      tick();
    end
    in_valid = 1'b0; rst = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_hold: in_ready=%b out_valid=%b want 0/0", in_ready, out_valid);
    end
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (stage_valid !== 4'b0000 || occupancy !== 3'd0 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++; $display("FAIL rstmid_clear: sv=%b occ=%0d valid=%b data=%h want 0000/0/0/0", stage_valid, occupancy, out_valid, out_data);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = (c == 0); in_data = 32'h44;
      #1;
      vectors++;
      if (c < 4) begin
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL rstmid_latency c=%0d: valid=%b want 0", c, out_valid);
        end
      end else if (out_valid !== 1'b1 || out_data !== 32'h44) begin
        errors++; $display("FAIL rstmid_exit: valid=%b data=%h want 1/44", out_valid, out_data);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_flush_output();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
